// File: rtl/spi_ram_arbiter.sv
// Two-requester round-robin arbiter and command sequencer for the SPI-side
// single-port RAM. Each accepted transaction becomes an address command
// followed by a data/read command. The result goes back to the requester
// that issued the transaction.
module spi_ram_arbiter #(
  parameter int RD_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  // requester 0
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_wr,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  // requester 1
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_wr,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  // RAM command port
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CMD_ADDR,
    CMD_DATA,
    RD_WAIT
  } state_t;

  state_t          state;
  logic            last_grant;   // id granted most recently; reset to 1 so requester 0 wins first
  logic            cur_id;
  logic            cur_wr;
  logic [7:0]      cur_addr;
  logic [7:0]      cur_wdata;
  logic [TW-1:0]   timer;

  logic            grant_vld;
  logic            grant_id;
  logic            sel_wr;
  logic [7:0]      sel_addr;
  logic [7:0]      sel_wdata;

  // Round-robin grant decision, only offered while idle and out of reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;

  assign sel_wr    = grant_id ? req1_wr    : req0_wr;
  assign sel_addr  = grant_id ? req1_addr  : req0_addr;
  assign sel_wdata = grant_id ? req1_wdata : req0_wdata;

  // Transaction sequencer; all RAM and response outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      cur_wr       <= 1'b0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
      timer        <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      // Pulsed outputs default to zero; the cases below raise them for one cycle.
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_err     <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur_id       <= grant_id;
            cur_wr       <= sel_wr;
            cur_addr     <= sel_addr;
            cur_wdata    <= sel_wdata;
            last_grant   <= grant_id;
            ram_rx_valid <= 1'b1;
            ram_din      <= {sel_wr ? OP_WADDR : OP_RADDR, sel_addr};
            state        <= CMD_ADDR;
          end
        end

        CMD_ADDR: begin
          ram_rx_valid <= 1'b1;
          ram_din      <= cur_wr ? {OP_WDATA, cur_wdata} : {OP_READ, 8'h00};
          state        <= CMD_DATA;
        end

        CMD_DATA: begin
          if (cur_wr) begin
            if (cur_id) rsp1_valid <= 1'b1;
            else        rsp0_valid <= 1'b1;
            state <= IDLE;
          end else begin
            timer <= '0;
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (ram_tx_valid) begin
            if (cur_id) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= ram_dout;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= ram_dout;
            end
            state <= IDLE;
          end else if (timer == TW'(RD_TIMEOUT - 1)) begin
            // Counter reaches RD_TIMEOUT on this edge: abort the read.
            if (cur_id) begin
              rsp1_valid <= 1'b1;
              rsp1_err   <= 1'b1;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_err   <= 1'b1;
            end
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: behavioural RAM model, scoreboard
// queues for RAM commands and responses, table-driven transactions plus
// hand-written sequences for arbitration, timeout, spurious data and reset.
module tb_spi_ram_arbiter;

  localparam int RD_TIMEOUT = 4;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_wr;
  logic [7:0] req0_addr, req0_wdata;
  logic       rsp0_valid, rsp0_err;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_wr;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp1_valid, rsp1_err;
  logic [7:0] rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  spi_ram_arbiter #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_waddr, ram_raddr;
  logic       model_tx;
  logic       ram_silent = 1'b0;
  logic       spur = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
    ram_waddr = 8'h00;
    ram_raddr = 8'h00;
    model_tx  = 1'b0;
    ram_dout  = 8'h00;
  end

  always @(posedge clk) begin
    model_tx <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_waddr <= ram_din[7:0];
        2'b01: ram_mem[ram_waddr] <= ram_din[7:0];
        2'b10: ram_raddr <= ram_din[7:0];
        2'b11: if (!ram_silent) begin
          model_tx <= 1'b1;
          ram_dout <= ram_mem[ram_raddr];
        end
      endcase
    end
  end

  assign ram_tx_valid = model_tx | spur;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [9:0] din;
    int         cyc;
  } cmd_t;

  typedef struct {
    bit         id;
    logic [7:0] rdata;
    bit         err;
    int         cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   grant_log[$];
  logic [7:0] ref_mem [256];

  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

  // Monitor: compares RAM commands and responses against expectations.
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    bit   act_id;
    logic [7:0] act_rd;
    logic act_err;
    if (rst_n) begin
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        c = cmd_q.pop_front();
        checks++; errors++;
        $display("FAIL cmd_missing: got none expected %03h at cycle %0d", c.din, c.cyc);
      end
      checks++;
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got %03h expected none at cycle %0d", ram_din, cyc);
        end else begin
          c = cmd_q.pop_front();
          if (ram_din !== c.din || c.cyc != cyc) begin
            errors++;
            $display("FAIL cmd: got %03h@%0d expected %03h@%0d", ram_din, cyc, c.din, c.cyc);
          end
        end
      end else if (ram_din !== 10'h000) begin
        errors++;
        $display("FAIL din_idle: got %03h expected 000", ram_din);
      end

      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        r = rsp_q.pop_front();
        checks++; errors++;
        $display("FAIL rsp_missing: got none expected id%0d at cycle %0d", r.id, r.cyc);
      end
      checks++;
      if (rsp0_valid || rsp1_valid) begin
        act_id  = rsp1_valid;
        act_rd  = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        act_err = rsp1_valid ? rsp1_err   : rsp0_err;
        if (rsp0_valid && rsp1_valid) begin
          errors++;
          $display("FAIL rsp_both: got both valid expected one");
        end else if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id%0d at cycle %0d expected none", act_id, cyc);
        end else begin
          r = rsp_q.pop_front();
          if (r.id != act_id || act_rd !== r.rdata || act_err !== r.err || r.cyc != cyc)
            begin
            errors++;
            $display("FAIL rsp: got id%0d rd=%02h err=%0b @%0d expected id%0d rd=%02h err=%0b @%0d",
                     act_id, act_rd, act_err, cyc, r.id, r.rdata, r.err, r.cyc);
          end
        end
      end
      if ((!rsp0_valid && (rsp0_rdata !== 8'h00 || rsp0_err !== 1'b0)) ||
          (!rsp1_valid && (rsp1_rdata !== 8'h00 || rsp1_err !== 1'b0))) begin
        errors++;
        $display("FAIL rsp_idle: got rd0=%02h e0=%0b rd1=%02h e1=%0b expected zeros",
                 rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_req(input bit id, input bit v, input bit wr,
                           input logic [7:0] addr, input logic [7:0] wdata);
    if (id) begin
      req1_valid = v; req1_wr = wr; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = v; req0_wr = wr; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  // Presents one transaction, waits (bounded) for accept, pushes expectations.
  task automatic issue(input bit id, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd, input bit exp_err);
    bit   accepted = 1'b0;
    bit   rdy;
    int   acc;
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    drive_req(id, 1'b1, wr, addr, wdata);
    for (int i = 0; i < 60 && !accepted; i++) begin
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy) begin
        accepted = 1'b1;
        acc = cyc + 1;
        c.din = {wr ? 2'b00 : 2'b10, addr};
        c.cyc = acc;
        cmd_q.push_back(c);
        c.din = wr ? {2'b01, wdata} : 10'h300;
        c.cyc = acc + 1;
        cmd_q.push_back(c);
        r.id    = id;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.cyc   = acc + (wr ? 2 : (exp_err ? 2 + RD_TIMEOUT : 3));
        rsp_q.push_back(r);
        grant_log.push_back(int'(id));
        if (wr) ref_mem[addr] = wdata;
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    drive_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
    check($sformatf("accept_id%0d_addr%02h", id, addr), 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((cmd_q.size() > 0 || rsp_q.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain_queues_empty", 32'(cmd_q.size() + rsp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ram"}, {ram_rx_valid, ram_din}, 32'h0);
    check({name, "_rsp0"}, {rsp0_valid, rsp0_err, rsp0_rdata}, 32'h0);
    check({name, "_rsp1"}, {rsp1_valid, rsp1_err, rsp1_rdata}, 32'h0);
    check({name, "_ready"}, {req1_ready, req0_ready}, 32'h0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit         id;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 1'b0, wr: 1'b1, addr: 8'h12, wdata: 8'hA5, exp_rd: 8'h00};
    vecs[1] = '{id: 1'b1, wr: 1'b0, addr: 8'h12, wdata: 8'h00, exp_rd: 8'hA5};
    vecs[2] = '{id: 1'b1, wr: 1'b1, addr: 8'hFF, wdata: 8'h3C, exp_rd: 8'h00};
    vecs[3] = '{id: 1'b0, wr: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rd: 8'h3C};
    vecs[4] = '{id: 1'b0, wr: 1'b1, addr: 8'h00, wdata: 8'h00, exp_rd: 8'h00};
    vecs[5] = '{id: 1'b1, wr: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rd: 8'h00};

    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    #2 rst_n = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++)
      issue(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);
    drain();

    // Both requesters hold three writes each: grants must alternate.
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, 8'h40 + 8'(i), 8'hA0 + 8'(i), 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, 8'h50 + 8'(i), 8'hB0 + 8'(i), 8'h00, 1'b0);
    join
    drain();
    check("grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 8'h40 + 8'(i), 8'h00, ref_mem[8'h40 + 8'(i)], 1'b0);
      issue(1'b1, 1'b0, 8'h50 + 8'(i), 8'h00, ref_mem[8'h50 + 8'(i)], 1'b0);
    end
    drain();

    // Read timeout: RAM never answers, then a normal read follows.
    ram_silent = 1'b1;
    issue(1'b0, 1'b0, 8'h41, 8'h00, 8'h00, 1'b1);
    drain();
    ram_silent = 1'b0;
    issue(1'b1, 1'b0, 8'h41, 8'h00, ref_mem[8'h41], 1'b0);
    drain();

    // Spurious tx_valid while idle: no response, next request accepted at once.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b0, 1'b1, 8'h70, 8'h5A, 8'h00, 1'b0);
    drain();
    issue(1'b1, 1'b0, 8'h70, 8'h00, 8'h5A, 1'b0);
    drain();

    // Reset during CMD_DATA of a write: outputs clear, no response issued.
    issue(1'b0, 1'b1, 8'h60, 8'h77, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_cmd_data", 32'(ram_din), 32'h177);
    rst_n = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    ref_mem[8'h60] = 8'h00;
    drive_req(1'b0, 1'b1, 1'b1, 8'h61, 8'h11);
    drive_req(1'b1, 1'b1, 1'b1, 8'h62, 8'h22);
    #1;
    check_all_zero("mid_reset");
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    grant_log.delete();
    fork
      issue(1'b0, 1'b1, 8'h61, 8'h11, 8'h00, 1'b0);
      issue(1'b1, 1'b1, 8'h62, 8'h22, 8'h00, 1'b0);
    join
    drain();
    check("post_reset_first_grant", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hFFFF, 32'd0);
    issue(1'b0, 1'b0, 8'h60, 8'h00, 8'h00, 1'b0);
    issue(1'b1, 1'b0, 8'h62, 8'h00, 8'h22, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Two-requester arbiter and command sequencer for the SPI-side single-port RAM.
- That RAM takes 10-bit commands {op[1:0], payload[7:0]} qualified by rx_valid, with these opcodes: 00 set write address, 01 write data, 10 set read address, 11 read (data returns with tx_valid one cycle later).
- This block turns whole read/write transactions from either requester into the two-command sequence the RAM expects, using round-robin arbitration.
- It returns read data or write completion to the requester that issued the transaction.

Parameters:
- RD_TIMEOUT, 4: cycles spent in RD_WAIT without ram_tx_valid before the read is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 transaction request; held until accepted
- req0_ready  out  1  requester 0 accept; combinational
- req0_wr  in  1  1 = write, 0 = read
- req0_addr  in  8  RAM address
- req0_wdata  in  8  write data
- rsp0_valid  out  1  one-cycle completion pulse to requester 0
- rsp0_rdata  out  8  read data; 0 for writes and errors
- rsp0_err  out  1  read timeout flag, valid with rsp0_valid
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as requester 0
- ram_din  out  10  command to RAM; registered
- ram_rx_valid  out  1  command qualifier; registered
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid

Behaviour:
- Reset (async): state IDLE, all outputs 0, rr pointer favours requester 0, timeout counter 0. Reset mid-transaction aborts it with no response issued.
- States: IDLE, CMD_ADDR, CMD_DATA, RD_WAIT.
- IDLE, grant:
  - If any reqN_valid is high, grant one. reqN_ready=1 for the granted requester only, in this cycle only, and only in IDLE.
  - Both valid: grant the requester not granted last. After reset, requester 0 wins.
  - On accept edge E0, latch wr/addr/wdata/id and update the rr pointer. Next state CMD_ADDR.
- CMD_ADDR (E0..E1): ram_rx_valid=1, ram_din={wr?2'b00:2'b10, addr}. Next state CMD_DATA.
- CMD_DATA (E1..E2): ram_rx_valid=1, ram_din = wr ? {2'b01, wdata} : {2'b11, 8'h00}.
  - Write: at E2 go to IDLE; rspN_valid=1 for one cycle, rdata=0, err=0.
  - Read: at E2 go to RD_WAIT and clear the timer.
- ram_rx_valid is high for exactly 2 consecutive cycles per transaction. When it is low, ram_din=0.
- RD_WAIT:
  - ram_tx_valid is expected during E2..E3. When sampled high, capture ram_dout into rspN_rdata, pulse rspN_valid with err=0, and go to IDLE.
  - The timer increments each cycle. When it reaches RD_TIMEOUT without tx_valid: rspN_valid=1, err=1, rdata=0, go to IDLE.
- Latency, accept to response pulse: write 2 cycles (pulse E2..E3); read 3 cycles (pulse E3..E4).
- Accept and response may overlap: a new accept can occur in the same cycle a response pulse is high. Minimum spacing between accepts is 3 cycles for writes and 4 for reads.
- ram_tx_valid outside RD_WAIT is ignored. The non-granted rsp outputs stay 0. rsp_rdata and err hold 0 except during the valid pulse.
- A requester changing its inputs while not accepted has no effect until the accept edge.

Test Plan:
- Requester 0 write addr 0x12 data 0xA5 -> ram_din 0x012 then 0x1A5 on consecutive cycles; rsp0_valid at +2 with err=0; rsp1_valid stays 0.
- Requester 1 read addr 0x12 after the above -> ram_din 0x212 then 0x300; RAM returns 0xA5; rsp1_valid at +3, rsp1_rdata=0xA5, err=0.
- Both valid after reset, each holding 3 writes -> grants alternate 0,1,0,1,0,1; each requester's data at its addresses reads back correctly.
- Read with a RAM model that never raises tx_valid, RD_TIMEOUT=4 -> rsp0_valid with err=1, rdata=0 after 4 RD_WAIT cycles; the next request is accepted normally.
- rst_n asserted during CMD_DATA of a write -> all outputs 0 immediately, no rsp pulse; after release requester 0 wins a simultaneous request.
- Spurious ram_tx_valid pulse while IDLE -> no rsp pulse and no state change.
